// File: rtl/traffic_phase_timer.sv
// Four-phase traffic-light sequencer with per-phase tick countdown and BCD digits for a 2-digit display.
// Optional night flashing-yellow mode when TL_NIGHT_FLASH_EN is defined.
module traffic_phase_timer #(
  parameter int CLK_DIV = 50,
  parameter int T_NS_G  = 30,
  parameter int T_NS_Y  = 5,
  parameter int T_EW_G  = 15,
  parameter int T_EW_Y  = 5,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef TL_NIGHT_FLASH_EN
  input  logic             night,
`endif
  output logic [1:0]       phase,
  output logic [2:0]       ns_lamp,
  output logic [2:0]       ew_lamp,
  output logic [CNT_W-1:0] cnt,
  output logic [3:0]       cnt_tens,
  output logic [3:0]       cnt_ones,
  output logic             phase_start
);

  localparam int PRESC_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] LD_NS_G = CNT_W'(T_NS_G - 1);
  localparam logic [CNT_W-1:0] LD_NS_Y = CNT_W'(T_NS_Y - 1);
  localparam logic [CNT_W-1:0] LD_EW_G = CNT_W'(T_EW_G - 1);
  localparam logic [CNT_W-1:0] LD_EW_Y = CNT_W'(T_EW_Y - 1);

  // Lamp encoding is {R,Y,G}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic bit t_ok(input int t);
    return (t >= 1) && (t <= 99) && (t < (1 << CNT_W));
  endfunction

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("traffic_phase_timer: CLK_DIV must be >= 2");
  end
  if (!t_ok(T_NS_G) || !t_ok(T_NS_Y) || !t_ok(T_EW_G) || !t_ok(T_EW_Y)) begin : g_bad_t
    $error("traffic_phase_timer: every T_* must be 1..99 and < 2**CNT_W");
  end

  typedef enum logic [1:0] {
    NS_G = 2'd0,
    NS_Y = 2'd1,
    EW_G = 2'd2,
    EW_Y = 2'd3
  } phase_e;

  phase_e               phase_q, phase_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           ns_lamp_q, ns_lamp_d;
  logic [2:0]           ew_lamp_q, ew_lamp_d;
  logic                 phase_start_q, phase_start_d;
  logic                 tick;
`ifdef TL_NIGHT_FLASH_EN
  logic                 flash_q, flash_d;
  logic                 flash_on_q, flash_on_d;
`endif

  function automatic phase_e succ(input phase_e p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return EW_G;
      EW_G:    return EW_Y;
      default: return NS_G;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] load_of(input phase_e p);
    case (p)
      NS_G:    return LD_NS_G;
      NS_Y:    return LD_NS_Y;
      EW_G:    return LD_EW_G;
      default: return LD_EW_Y;
    endcase
  endfunction

  // Exactly one direction is ever non-red, because both lamps come from a single phase value.
  function automatic logic [5:0] lamps_of(input phase_e p);
    case (p)
      NS_G:    return {LAMP_G, LAMP_R};
      NS_Y:    return {LAMP_Y, LAMP_R};
      EW_G:    return {LAMP_R, LAMP_G};
      default: return {LAMP_R, LAMP_Y};
    endcase
  endfunction

  assign tick = en && (presc_q == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= NS_G;
      presc_q       <= '0;
      cnt_q         <= LD_NS_G;
      ns_lamp_q     <= LAMP_G;
      ew_lamp_q     <= LAMP_R;
      phase_start_q <= 1'b0;
`ifdef TL_NIGHT_FLASH_EN
      flash_q       <= 1'b0;
      flash_on_q    <= 1'b0;
`endif
    end else begin
      phase_q       <= phase_d;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      ns_lamp_q     <= ns_lamp_d;
      ew_lamp_q     <= ew_lamp_d;
      phase_start_q <= phase_start_d;
`ifdef TL_NIGHT_FLASH_EN
      flash_q       <= flash_d;
      flash_on_q    <= flash_on_d;
`endif
    end
  end

  always_comb begin
    phase_d       = phase_q;
    presc_d       = presc_q;
    cnt_d         = cnt_q;
    phase_start_d = 1'b0;

    if (en) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        phase_d       = succ(phase_q);
        cnt_d         = load_of(succ(phase_q));
        phase_start_d = 1'b1;
      end
    end

`ifdef TL_NIGHT_FLASH_EN
    flash_d    = flash_q;
    flash_on_d = flash_on_q;
    // Night mode overrides any phase advance decided above in the same cycle.
    if (night) begin
      phase_d       = NS_Y;
      cnt_d         = '0;
      phase_start_d = 1'b0;
      if (!flash_q) begin
        flash_d    = 1'b1;
        flash_on_d = 1'b1;
        presc_d    = '0;
      end else if (tick) begin
        flash_on_d = !flash_on_q;
      end
    end else if (flash_q) begin
      flash_d       = 1'b0;
      flash_on_d    = 1'b0;
      phase_d       = NS_G;
      cnt_d         = LD_NS_G;
      presc_d       = '0;
      phase_start_d = 1'b1;
    end
`endif
  end

  always_comb begin
    {ns_lamp_d, ew_lamp_d} = lamps_of(phase_d);
`ifdef TL_NIGHT_FLASH_EN
    if (flash_d) begin
      ns_lamp_d = flash_on_d ? LAMP_Y : 3'b000;
      ew_lamp_d = flash_on_d ? LAMP_Y : 3'b000;
    end
`endif
  end

  // cnt never exceeds 98, so a compare chain for the tens digit is enough.
  always_comb begin
    cnt_tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (int'(cnt_q) >= i * 10) cnt_tens = 4'(i);
    end
    cnt_ones = 4'(int'(cnt_q) - int'(cnt_tens) * 10);
  end

  assign phase       = phase_q;
  assign cnt         = cnt_q;
  assign ns_lamp     = ns_lamp_q;
  assign ew_lamp     = ew_lamp_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed steps plus random enable patterns against a tick-arithmetic model.
module tb_traffic_phase_timer;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 7;
  localparam int TOTAL   = 3 + 1 + 2 + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       phase;
  logic [2:0]       ns_lamp, ew_lamp;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cnt_tens, cnt_ones;
  logic             phase_start;

  logic             rst2_n = 1'b0;
  logic             en2 = 1'b1;
  logic [1:0]       phase2;
  logic [2:0]       ns_lamp2, ew_lamp2;
  logic [6:0]       cnt2;
  logic [3:0]       cnt_tens2, cnt_ones2;
  logic             phase_start2;

  int checks = 0;
  int errors = 0;
  int e_cnt = 0;
  bit last_en = 1'b0;
  int t_arr [4];

  traffic_phase_timer #(
    .CLK_DIV(CLK_DIV), .T_NS_G(3), .T_NS_Y(1), .T_EW_G(2), .T_EW_Y(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase(phase), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
    .cnt(cnt), .cnt_tens(cnt_tens), .cnt_ones(cnt_ones), .phase_start(phase_start)
  );

  traffic_phase_timer dut_def (
    .clk(clk), .rst_n(rst2_n), .en(en2), .phase(phase2), .ns_lamp(ns_lamp2), .ew_lamp(ew_lamp2),
    .cnt(cnt2), .cnt_tens(cnt_tens2), .cnt_ones(cnt_ones2), .phase_start(phase_start2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the state is a pure function of how many enabled clock edges have passed since reset.
  task automatic check_all(input string tag);
    int ticks, pos, ph, cn, ps;
    logic [2:0] ns_e, ew_e;
    ticks = e_cnt / CLK_DIV;
    pos   = ticks % TOTAL;
    ph    = 0;
    while (pos >= t_arr[ph]) begin
      pos -= t_arr[ph];
      ph++;
    end
    cn = t_arr[ph] - 1 - pos;
    ps = (last_en && e_cnt > 0 && (e_cnt % CLK_DIV) == 0 && pos == 0) ? 1 : 0;
    ns_e = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
    ew_e = (ph == 2) ? 3'b001 : (ph == 3) ? 3'b010 : 3'b100;
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".cnt"}, 32'(cnt), 32'(cn));
    check({tag, ".tens"}, 32'(cnt_tens), 32'(cn / 10));
    check({tag, ".ones"}, 32'(cnt_ones), 32'(cn % 10));
    check({tag, ".ns"}, 32'(ns_lamp), 32'(ns_e));
    check({tag, ".ew"}, 32'(ew_lamp), 32'(ew_e));
    check({tag, ".pstart"}, 32'(phase_start), 32'(ps));
    check({tag, ".safe"}, ((ns_lamp !== 3'b100) && (ew_lamp !== 3'b100)) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Called at a falling edge; applies en across the next rising edge and returns at the following fall.
  task automatic step(input bit en_v);
    en = en_v;
    @(posedge clk);
    if (en_v) e_cnt++;
    last_en = en_v;
    @(negedge clk);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    e_cnt   = 0;
    last_en = 1'b0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    t_arr[0] = 3; t_arr[1] = 1; t_arr[2] = 2; t_arr[3] = 1;

    // Default-parameter instance: BCD of 29, 9 and 0.
    @(negedge clk);
    check("def.reset.cnt", 32'(cnt2), 32'd29);
    check("def.reset.tens", 32'(cnt_tens2), 32'd2);
    check("def.reset.ones", 32'(cnt_ones2), 32'd9);
    check("def.reset.ns", 32'(ns_lamp2), 32'b001);
    check("def.reset.ew", 32'(ew_lamp2), 32'b100);
    rst2_n = 1'b1;
    repeat (20 * 50) @(negedge clk);
    check("def.c9.cnt", 32'(cnt2), 32'd9);
    check("def.c9.tens", 32'(cnt_tens2), 32'd0);
    check("def.c9.ones", 32'(cnt_ones2), 32'd9);
    repeat (9 * 50) @(negedge clk);
    check("def.c0.cnt", 32'(cnt2), 32'd0);
    check("def.c0.tens", 32'(cnt_tens2), 32'd0);
    check("def.c0.ones", 32'(cnt_ones2), 32'd0);
    check("def.c0.phase", 32'(phase2), 32'd0);
    check("def.c0.pstart", 32'(phase_start2), 32'd0);

    // Reset state, then the first phase with en held high.
    check_all("reset");
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      check_all("run1");
      if (i == 4) check("run1.c4.cnt", 32'(cnt), 32'd1);
    end
    check("run1.c12.phase", 32'(phase), 32'd1);
    check("run1.c12.ns", 32'(ns_lamp), 32'b010);
    check("run1.c12.pstart", 32'(phase_start), 32'd1);
    check("run1.c12.cnt", 32'(cnt), 32'd0);

    // Rest of a full cycle back to NS_G.
    for (int i = 0; i < 16; i++) begin
      step(1'b1);
      check_all("cycle");
    end
    check("cycle.end.phase", 32'(phase), 32'd0);
    check("cycle.end.pstart", 32'(phase_start), 32'd1);

    // Freeze at cnt=1, prescaler=2 and resume.
    async_reset_pulse("hold.rst");
    repeat (6) begin
      step(1'b1);
      check_all("hold.pre");
    end
    check("hold.pre.cnt", 32'(cnt), 32'd1);
    repeat (10) begin
      step(1'b0);
      check_all("hold.frozen");
    end
    step(1'b1);
    check("hold.resume1.cnt", 32'(cnt), 32'd1);
    step(1'b1);
    check("hold.resume2.cnt", 32'(cnt), 32'd0);
    check_all("hold.resume2");

    // Asynchronous reset in the middle of EW_G.
    async_reset_pulse("ewg.pre");
    repeat (18) step(1'b1);
    check("ewg.mid.phase", 32'(phase), 32'd2);
    async_reset_pulse("ewg.rst");
    check("ewg.rst.cnt", 32'(cnt), 32'd2);

    // Randomized enable with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset_pulse("rand.rst");
      end else begin
        step($urandom_range(0, 3) != 0);
        check_all("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
